fifo_wr_frontend: RTL and testbench
===================================

// Module: fifo_wr_frontend
// PURPOSE
//  Write-side front end of the async FIFO, in the wclk domain, directly upstream of wptr_full.
//  Converts a valid/ready producer stream into winc/wdata, holding data while wfull is high.
//  Uses a 2-entry skid buffer so that s_ready is registered.
//  Derives a conservative fill level and almost-full flag from wptr and the synchronised wq2_rptr.
// PARAMETERS
//  ADDR       4   FIFO address width; depth = 2**ADDR; pointers are ADDR+1 bits, Gray-coded
//  DSIZE      8   data width
//  AF_THRESH  12  walmost_full asserts when wlevel >= AF_THRESH (1..2**ADDR)
// PORTS
//  wclk          in   1       write-domain clock; single clock, all logic posedge wclk
//  wrst          in   1       asynchronous, active-high reset
//  s_valid       in   1       producer has data
//  s_data        in   DSIZE   producer data
//  s_ready       out  1       front end can accept (registered)
//  wfull         in   1       registered full flag from wptr_full
//  wptr          in   ADDR+1  Gray write pointer from wptr_full
//  wq2_rptr      in   ADDR+1  Gray read pointer, already 2-flop synchronised into wclk
//  winc          out  1       write request to wptr_full and the memory write enable
//  wdata         out  DSIZE   write data to FIFO memory, valid whenever winc=1
//  wlevel        out  ADDR+1  registered occupancy estimate, 0..2**ADDR
//  walmost_full  out  1       registered, wlevel >= AF_THRESH
//  wlevel_err    out  1       sticky: wlevel computed > 2**ADDR (pointer corruption)
// BEHAVIOUR
//  Reset (wrst=1, async):
//   - skid entries are invalid; s_ready=0, winc=0, wdata=0, wlevel=0.
//   - walmost_full=0 and wlevel_err=0.
//   - s_ready rises on the first wclk edge after wrst falls.
//  Skid buffer: head entry (drives wdata) and spare entry.
//   - Accept: s_valid & s_ready.
//   - Pop: winc.
//   - An accept into the empty buffer loads head.
//   - An accept while head is valid and not popping loads spare.
//   - On pop, spare (if valid) moves to head, else the incoming beat goes to head.
//   - Simultaneous accept and pop with one entry valid gives zero bubbles, 1 beat/cycle.
//   - s_ready_next = ~(both entries valid after this edge); s_data is never dropped.
//   - Latency: a beat accepted at edge N is on wdata after N; winc can assert in cycle N+1.
//  Handshake with wptr_full:
//   - winc = head_valid & ~wfull (combinational from registers plus the wfull input).
//   - wptr_full advances only on winc & ~wfull, so every winc pulse is exactly one stored word.
//   - wfull high: winc=0, head/spare hold, s_ready falls once spare fills (max 2 beats buffered).
//   - wfull falling: winc resumes the same cycle; data order is preserved.
//  Level:
//   - wbin = gray2bin(wptr); rbin = gray2bin(wq2_rptr); diff = wbin - rbin mod 2**(ADDR+1).
//   - wlevel <= diff, registered; 1 cycle behind the pointers.
//   - wlevel over-estimates occupancy because rptr lags by 2+ cycles; it never under-estimates.
//   - Wrap-around: MSB toggles across the wrap; modular subtraction is correct.
//   - Example with ADDR=4: wptr bin 17, rptr bin 31 gives diff = (17 - 31) mod 32 = 18.
//     That exceeds 16, so wlevel_err is set.
//   - diff > 2**ADDR sets wlevel_err (sticky until reset); wlevel still shows diff.
//  Reset mid-operation: buffered beats are discarded and no winc is issued.
//   - The upstream producer and wptr_full are reset by the same wrst.
// STRUCTURE
//  fifo_pkg:
//   - function gray2bin(logic [ADDR:0]);
//   - localparam DEPTH = 2**ADDR;
//   - typedef struct {logic v; logic [DSIZE-1:0] d;} skid_ent_t (parameterised by DSIZE
//     via package default 8).
//  Sub-module wr_skid_buf (DSIZE):
//   - 2-entry skid buffer with s_valid/s_ready in and head_valid/head_data/pop.
//  The top level holds the winc gating, the level arithmetic and the flags.
// TESTING
//  - Reset: wrst=1 mid-stream with 2 beats buffered -> after release s_ready=0 for 1 cycle,
//    then 1; winc never pulses; wlevel=0.
//  - Streaming: ADDR=4, wfull=0, s_valid=1 with data 0x01..0x10 -> winc contiguous for 16 cycles
//    from cycle 2; wdata order 0x01..0x10; s_ready stays 1.
//  - Full stall: wfull=1 while streaming 0xA0,0xA1,0xA2 -> winc=0, s_ready=0 after 2 accepts,
//    0xA2 held at producer. Drop wfull -> wdata 0xA0, 0xA1, 0xA2, no loss or duplicate.
//  - Level/almost-full: wptr=gray(12), wq2_rptr=gray(0) -> next cycle wlevel=12, walmost_full=1.
//    Then wq2_rptr=gray(1) -> wlevel=11, walmost_full=0.
//  - Wrap: wptr=gray(3), wq2_rptr=gray(27) -> wlevel=8, wlevel_err=0.
//    Then wq2_rptr=gray(2), wptr=gray(31) -> wlevel=29, wlevel_err=1 and stays 1 until wrst.
//  - Simultaneous: one beat in head, s_valid=1 and pop in the same cycle with wfull=0
//    -> next cycle the head holds the new beat, spare is empty, s_ready=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side logic.
// Pointer width and data width defaults live here so every block agrees on them.
package fifo_pkg;

    localparam int FIFO_ADDR      = 4;
    localparam int FIFO_DSIZE     = 8;
    localparam int FIFO_AF_THRESH = 12;
    localparam int DEPTH          = 2 ** FIFO_ADDR;

    typedef struct packed {
        logic                  v;
        logic [FIFO_DSIZE-1:0] d;
    } skid_ent_t;

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [FIFO_ADDR:0] gray2bin(input logic [FIFO_ADDR:0] g);
        logic [FIFO_ADDR:0] b;
        b[FIFO_ADDR] = g[FIFO_ADDR];
        for (int i = FIFO_ADDR - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wr_skid_buf.sv
// Two-entry skid buffer: head drives the consumer, spare absorbs the beat in flight
// when the consumer stalls, so s_ready can come straight from a flop.
module wr_skid_buf
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    output logic             s_ready,
    output logic             head_valid,
    output logic [DSIZE-1:0] head_data,
    input  logic             pop
);

    skid_ent_t head_q, head_d;
    skid_ent_t spare_q, spare_d;
    logic      s_ready_q, s_ready_d;
    logic      accept;

    assign accept = s_valid & s_ready_q;

    always_comb begin
        head_d  = head_q;
        spare_d = spare_q;
        if (pop) begin
            if (spare_q.v) begin
                head_d    = spare_q;
                spare_d.v = accept;
                if (accept) spare_d.d = s_data;
            end else begin
                head_d.v = accept;
                if (accept) head_d.d = s_data;
            end
        end else if (accept) begin
            // s_ready high guarantees at least one slot is free here.
            if (!head_q.v) begin
                head_d.v = 1'b1;
                head_d.d = s_data;
            end else begin
                spare_d.v = 1'b1;
                spare_d.d = s_data;
            end
        end
        s_ready_d = ~(head_d.v & spare_d.v);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            spare_q   <= '0;
            s_ready_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            spare_q   <= spare_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign head_valid = head_q.v;
    assign head_data  = head_q.d;

endmodule

// File: rtl/fifo_wr_frontend.sv
// Write-side front end: valid/ready stream to winc/wdata with full-stall holding,
// plus a conservative (never low) occupancy estimate and its flags.
module fifo_wr_frontend
    import fifo_pkg::*;
#(
    parameter int ADDR      = FIFO_ADDR,
    parameter int DSIZE     = FIFO_DSIZE,
    parameter int AF_THRESH = FIFO_AF_THRESH
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    output logic             s_ready,
    input  logic             wfull,
    input  logic [ADDR:0]    wptr,
    input  logic [ADDR:0]    wq2_rptr,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    output logic [ADDR:0]    wlevel,
    output logic             walmost_full,
    output logic             wlevel_err
);

    localparam logic [ADDR:0] LVL_MAX = (ADDR+1)'(2 ** ADDR);
    localparam logic [ADDR:0] AF_LVL  = (ADDR+1)'(AF_THRESH);

    logic            head_valid;
    logic [ADDR:0]   wbin, rbin, diff;
    logic [ADDR:0]   wlevel_q;
    logic            walmost_full_q, wlevel_err_q;

    wr_skid_buf #(
        .DSIZE(DSIZE)
    ) u_skid (
        .clk       (wclk),
        .rst       (wrst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .head_valid(head_valid),
        .head_data (wdata),
        .pop       (winc)
    );

    // wptr_full only advances on winc & ~wfull, so gating here makes each pulse one word.
    assign winc = head_valid & ~wfull;

    assign wbin = gray2bin(wptr);
    assign rbin = gray2bin(wq2_rptr);
    assign diff = wbin - rbin;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wlevel_q       <= '0;
            walmost_full_q <= 1'b0;
            wlevel_err_q   <= 1'b0;
        end else begin
            wlevel_q       <= diff;
            walmost_full_q <= (diff >= AF_LVL);
            if (diff > LVL_MAX) wlevel_err_q <= 1'b1;
        end
    end

    assign wlevel       = wlevel_q;
    assign walmost_full = walmost_full_q;
    assign wlevel_err   = wlevel_err_q;

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Directed bench for fifo_wr_frontend: level vectors from a table, handshake corners by hand.
module tb_fifo_wr_frontend;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       wfull = 1'b0;
    logic [4:0] wptr = 5'd0;
    logic [4:0] wq2_rptr = 5'd0;
    logic       winc;
    logic [7:0] wdata;
    logic [4:0] wlevel;
    logic       walmost_full;
    logic       wlevel_err;

    int n_chk  = 0;
    int n_fail = 0;

    fifo_wr_frontend #(.ADDR(4), .DSIZE(8), .AF_THRESH(12)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .wfull       (wfull),
        .wptr        (wptr),
        .wq2_rptr    (wq2_rptr),
        .winc        (winc),
        .wdata       (wdata),
        .wlevel      (wlevel),
        .walmost_full(walmost_full),
        .wlevel_err  (wlevel_err)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int   wb;
        int   rb;
        int   lvl;
        logic af;
        logic err;
    } lvl_vec_t;

    lvl_vec_t lv [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   exp, cnt, first, last, nacc, wincs, seen;
        logic rdy_ok;

        lv[0] = '{12,  0, 12, 1'b1, 1'b0};
        lv[1] = '{12,  1, 11, 1'b0, 1'b0};
        lv[2] = '{ 0,  0,  0, 1'b0, 1'b0};
        lv[3] = '{16,  0, 16, 1'b1, 1'b0};
        lv[4] = '{ 3, 27,  8, 1'b0, 1'b0};
        lv[5] = '{ 5,  0,  5, 1'b0, 1'b0};
        lv[6] = '{20,  8, 12, 1'b1, 1'b0};
        lv[7] = '{ 7, 31,  8, 1'b0, 1'b0};

        // Reset state
        tick;
        tick;
        check("rst_s_ready", s_ready, 0);
        check("rst_winc", winc, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wlevel", wlevel, 0);
        check("rst_af", walmost_full, 0);
        check("rst_err", wlevel_err, 0);
        wrst = 1'b0;
        #1;
        check("rel_s_ready_low", s_ready, 0);
        tick;
        check("rel_s_ready_high", s_ready, 1);

        // Streaming 0x01..0x10 with no backpressure
        s_valid = 1'b1;
        s_data  = 8'h01;
        exp = 1; cnt = 0; first = -1; last = -1; rdy_ok = 1'b1;
        for (int c = 0; c < 60 && exp <= 16; c++) begin
            acc = s_valid & s_ready;
            if (!s_ready) rdy_ok = 1'b0;
            if (winc) begin
                check("stream_wdata", wdata, exp);
                exp++;
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
            tick;
            if (acc) begin
                if (s_data == 8'h10) s_valid = 1'b0;
                else s_data = s_data + 8'h01;
            end
        end
        check("stream_cnt", cnt, 16);
        check("stream_first", first, 1);
        check("stream_contig", last - first + 1, 16);
        check("stream_ready", rdy_ok, 1);
        #1;
        check("stream_idle_winc", winc, 0);

        // Full stall with three beats offered
        wfull   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA0;
        nacc = 0; wincs = 0;
        for (int c = 0; c < 5; c++) begin
            acc = s_valid & s_ready;
            if (winc) wincs++;
            tick;
            if (acc) begin
                nacc++;
                if (s_data == 8'hA2) s_valid = 1'b0;
                else s_data = s_data + 8'h01;
            end
        end
        check("stall_accepts", nacc, 2);
        check("stall_winc", wincs, 0);
        check("stall_s_ready", s_ready, 0);
        check("stall_wdata", wdata, 8'hA0);
        check("stall_held", s_data, 8'hA2);
        wfull = 1'b0;
        #1;
        check("stall_resume_winc", winc, 1);
        exp = 8'hA0;
        for (int c = 0; c < 10; c++) begin
            acc = s_valid & s_ready;
            if (winc) begin
                check("drain_wdata", wdata, exp);
                exp++;
            end
            tick;
            if (acc) begin
                if (s_data == 8'hA2) s_valid = 1'b0;
                else s_data = s_data + 8'h01;
            end
        end
        check("drain_count", exp, 8'hA3);
        check("drain_idle", winc, 0);

        // Simultaneous accept and pop with one beat in head
        wfull   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h55;
        tick;
        s_valid = 1'b0;
        #1;
        check("simul_head", wdata, 8'h55);
        check("simul_held", winc, 0);
        wfull   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h66;
        #1;
        check("simul_pop", winc, 1);
        check("simul_rdy", s_ready, 1);
        tick;
        s_valid = 1'b0;
        check("simul_new_head", wdata, 8'h66);
        check("simul_winc", winc, 1);
        check("simul_rdy_after", s_ready, 1);
        tick;
        check("simul_spare_empty", winc, 0);

        // Level table
        for (int i = 0; i < 8; i++) begin
            wptr     = gray(lv[i].wb);
            wq2_rptr = gray(lv[i].rb);
            tick;
            check($sformatf("lvl_%0d", i), wlevel, lv[i].lvl);
            check($sformatf("af_%0d", i), walmost_full, lv[i].af);
            check($sformatf("err_%0d", i), wlevel_err, lv[i].err);
        end

        // Corrupt pointer distance sets a sticky error
        wptr     = gray(17);
        wq2_rptr = gray(31);
        tick;
        check("err_lvl18", wlevel, 18);
        check("err_set18", wlevel_err, 1);
        wptr     = gray(31);
        wq2_rptr = gray(2);
        tick;
        check("err_lvl29", wlevel, 29);
        check("err_set29", wlevel_err, 1);
        wptr     = gray(0);
        wq2_rptr = gray(0);
        tick;
        check("err_sticky_lvl", wlevel, 0);
        check("err_sticky", wlevel_err, 1);

        // Reset with two beats buffered
        wfull   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hC0;
        tick;
        s_data  = 8'hC1;
        tick;
        s_valid = 1'b0;
        check("mid_full_rdy", s_ready, 0);
        wrst  = 1'b1;
        wfull = 1'b0;
        #1;
        check("mid_rst_winc", winc, 0);
        check("mid_rst_rdy", s_ready, 0);
        check("mid_rst_err", wlevel_err, 0);
        check("mid_rst_lvl", wlevel, 0);
        tick;
        tick;
        wrst = 1'b0;
        #1;
        check("mid_rel_rdy0", s_ready, 0);
        seen = 0;
        if (winc) seen++;
        tick;
        check("mid_rel_rdy1", s_ready, 1);
        for (int c = 0; c < 4; c++) begin
            if (winc) seen++;
            tick;
        end
        check("mid_no_winc", seen, 0);
        check("mid_wlevel", wlevel, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
